// File: rtl/adapter_pkg.sv
// Shared types and sizing helpers for the adapter input arbiter and its picker.
package adapter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  function automatic int beat_width(input int maxbeats);
    return (maxbeats > 1) ? $clog2(maxbeats) : 1;
  endfunction

  localparam int DEF_MAXBEATS = 16;
  localparam int BEAT_W       = beat_width(DEF_MAXBEATS);

endpackage

// File: rtl/adapter_arbiter_if.sv
// Stream bundle between NREQ upstream requesters, the arbiter and the width adapter.
interface adapter_arbiter_if
  import adapter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 64,
  parameter int IDW  = idw(NREQ)
);
  logic [NREQ*DW-1:0] idata;
  logic [NREQ-1:0]    ivalid;
  logic [NREQ-1:0]    ilast;
  logic [NREQ-1:0]    iready;
  logic [DW-1:0]      odata;
  logic               ovalid;
  logic               olast;
  logic [IDW-1:0]     oid;
  logic               oready;

  modport slave (
    input  idata, ivalid, ilast, oready,
    output iready, odata, ovalid, olast, oid
  );

  modport master (
    output idata, ivalid, ilast, oready,
    input  iready, odata, ovalid, olast, oid
  );
endinterface

// File: rtl/adapter_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  int cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = IDW'(cand);
      end
    end
  end

endmodule

// File: rtl/adapter_arbiter.sv
// Packet-level round-robin arbiter sharing one width-adapter input between NREQ streams.
module adapter_arbiter
  import adapter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DW       = 64,
  parameter int MAXBEATS = 16
) (
  input logic              clk,
  input logic              rst,
  adapter_arbiter_if.slave bus
);

  localparam int IDW = idw(NREQ);
  localparam int BW  = beat_width(MAXBEATS);
  localparam logic [BW-1:0]  BEAT_LAST = BW'(MAXBEATS - 1);
  localparam logic [IDW-1:0] G_MAX     = IDW'(NREQ - 1);

  state_t          state_reg;
  logic [IDW-1:0]  g_reg;
  logic [IDW-1:0]  rr_ptr_reg;
  logic [BW-1:0]   beat_reg;

  logic            pick_any;
  logic [IDW-1:0]  pick_idx;
  logic            busy;
  logic            fire;
  logic            ilast_g;
  logic [NREQ-1:0] sel;
  logic [DW-1:0]   slice [NREQ];
  logic [DW-1:0]   odata_mux;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req (bus.ivalid),
    .ptr (rr_ptr_reg),
    .any (pick_any),
    .idx (pick_idx)
  );

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign slice[gi] = bus.idata[gi*DW +: DW];
      assign sel[gi]   = (g_reg == IDW'(gi));
    end
  endgenerate

  // Reset gates the datapath immediately so an in-flight grant is dropped this cycle.
  assign busy    = (state_reg == BUSY) && !rst;
  assign ilast_g = |(bus.ilast & sel);

  always_comb begin
    odata_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel[i]) odata_mux = slice[i];
    end
  end

  assign bus.ovalid = busy && |(bus.ivalid & sel);
  assign bus.odata  = busy ? odata_mux : '0;
  assign bus.iready = (busy && bus.oready) ? sel : '0;
  assign bus.olast  = bus.ovalid && (ilast_g || (beat_reg == BEAT_LAST));
  assign fire       = bus.ovalid && bus.oready;

  generate
    if (NREQ == 1) begin : g_oid_tied
      assign bus.oid = '0;
    end else begin : g_oid_reg
      assign bus.oid = g_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      g_reg      <= '0;
      rr_ptr_reg <= '0;
      beat_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_any) begin
            g_reg     <= pick_idx;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (fire) begin
            if (bus.olast) begin
              state_reg  <= IDLE;
              beat_reg   <= '0;
              // A forced split also moves past g, so the remainder queues behind the others.
              rr_ptr_reg <= (g_reg == G_MAX) ? '0 : g_reg + 1'b1;
            end else begin
              beat_reg <= beat_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adapter_arbiter.sv
// Self-checking bench: packet-queue reference model of the round-robin adapter arbiter.
module tb_adapter_arbiter;
  import adapter_pkg::*;

  localparam int NREQ     = 4;
  localparam int DW       = 32;
  localparam int MAXBEATS = 4;
  localparam int IDW      = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adapter_arbiter_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus ();

  adapter_arbiter #(.NREQ(NREQ), .DW(DW), .MAXBEATS(MAXBEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Per-requester beat queues: {last, data}. Head of queue is what upstream presents.
  bit [DW:0] q [NREQ][$];
  int m_owner, m_ptr, m_cnt;
  int cyc = 0;
  int log_id[$];
  bit log_last[$];
  int log_cyc[$];

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
  endtask

  task automatic clear_queues();
    for (int k = 0; k < NREQ; k++) q[k].delete();
  endtask

  task automatic push_packet(input int k, input int len);
    bit [DW:0] w;
    for (int b = 0; b < len; b++) begin
      w = {(b == len - 1), DW'($urandom())};
      q[k].push_back(w);
    end
  endtask

  task automatic drive_inputs(input bit ordy);
    bit [DW:0] h;
    for (int k = 0; k < NREQ; k++) begin
      if (q[k].size() > 0) begin
        h = q[k][0];
        bus.ivalid[k] = 1'b1;
        bus.idata[k*DW +: DW] = h[DW-1:0];
        bus.ilast[k] = h[DW];
      end else begin
        bus.ivalid[k] = 1'b0;
        bus.idata[k*DW +: DW] = DW'($urandom());
        bus.ilast[k] = 1'b0;
      end
    end
    bus.oready = ordy;
  endtask

  // One clock cycle starting at a falling edge: drive, check, advance model, clock.
  task automatic step(input bit ordy);
    bit [DW:0] h;
    bit exp_v, exp_l;
    logic [NREQ-1:0] exp_rdy;
    logic [DW-1:0] exp_d;
    int c;
    drive_inputs(ordy);
    #1;
    exp_v = 1'b0; exp_l = 1'b0; exp_rdy = '0; exp_d = '0;
    if (m_owner >= 0) begin
      exp_v = (q[m_owner].size() > 0);
      if (ordy) exp_rdy[m_owner] = 1'b1;
      if (exp_v) begin
        h = q[m_owner][0];
        exp_d = h[DW-1:0];
        exp_l = h[DW] || (m_cnt == MAXBEATS - 1);
      end
    end
    tests_run++;
    if ({bus.ovalid, bus.olast, bus.iready} !== {exp_v, exp_l, exp_rdy}) begin
      tests_failed++;
      $display("FAIL handshake cyc=%0d: got v/l/rdy=%b/%b/%b expected %b/%b/%b", cyc,
               bus.ovalid, bus.olast, bus.iready, exp_v, exp_l, exp_rdy);
    end
    if (exp_v) begin
      tests_run++;
      if ({bus.oid, bus.odata} !== {IDW'(m_owner), exp_d}) begin
        tests_failed++;
        $display("FAIL beat cyc=%0d: got oid=%0d data=%h expected oid=%0d data=%h", cyc,
                 bus.oid, bus.odata, m_owner, exp_d);
      end
    end
    if (m_owner < 0) begin
      for (int i = 0; i < NREQ; i++) begin
        c = (m_ptr + i) % NREQ;
        if (q[c].size() > 0) begin
          m_owner = c;
          m_cnt = 0;
          break;
        end
      end
    end else if (exp_v && ordy) begin
      log_id.push_back(m_owner);
      log_last.push_back(exp_l);
      log_cyc.push_back(cyc);
      void'(q[m_owner].pop_front());
      if (exp_l) begin
        m_ptr = (m_owner + 1) % NREQ;
        m_owner = -1;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // mode 0: oready=1, mode 1: alternate starting with 1 on the first busy cycle, mode 2: random.
  task automatic run(input int mode, input int stop_fires, input int budget);
    int i = 0;
    int n0 = log_id.size();
    bit empty;
    bit ordy;
    while (1) begin
      empty = 1'b1;
      for (int k = 0; k < NREQ; k++) if (q[k].size() > 0) empty = 1'b0;
      if (empty && m_owner < 0) break;
      if (stop_fires > 0 && (log_id.size() - n0) >= stop_fires) break;
      if (i >= budget) begin
        tests_run++;
        tests_failed++;
        $display("FAIL timeout: got %0d cycles without draining, required <= %0d", i, budget);
        break;
      end
      ordy = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 2 == 1) : ($urandom_range(0, 3) != 0);
      step(ordy);
      i++;
    end
    drive_inputs(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ivalid = '1; bus.ilast = '1; bus.idata = '1; bus.oready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if ({bus.ovalid, bus.olast, bus.iready, bus.oid} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b l=%b rdy=%b oid=%0d expected all 0",
               bus.ovalid, bus.olast, bus.iready, bus.oid);
    end
    rst = 1'b0;
    clear_queues();
    model_reset();
    drive_inputs(1'b1);
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int exp_ids[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int n0 = log_id.size();
    for (int k = 0; k < NREQ; k++) begin
      push_packet(k, 1);
      push_packet(k, 1);
    end
    run(0, 0, 200);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (log_id.size() <= n0 + i || log_id[n0+i] !== exp_ids[i] || log_last[n0+i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_order[%0d]: got id=%0d expected id=%0d (single-beat)", i,
                 (log_id.size() > n0 + i) ? log_id[n0+i] : -1, exp_ids[i]);
      end else if (i > 0 && (log_cyc[n0+i] - log_cyc[n0+i-1]) != 2) begin
        tests_failed++;
        $display("FAIL rr_bubble[%0d]: got gap %0d expected 2", i,
                 log_cyc[n0+i] - log_cyc[n0+i-1]);
      end
    end
  endtask

  task automatic test_handover();
    int exp_ids[6]  = '{2, 2, 2, 0, 3, 0};
    bit exp_last[6] = '{0, 0, 1, 1, 1, 1};
    int n0;
    push_packet(1, 1);
    run(0, 0, 50);
    n0 = log_id.size();
    push_packet(2, 3);
    push_packet(0, 1);
    run(0, 0, 50);
    push_packet(0, 1);
    push_packet(3, 1);
    run(0, 0, 50);
    for (int i = 0; i < 6; i++) begin
      tests_run++;
      if (log_id.size() <= n0 + i || log_id[n0+i] !== exp_ids[i] || log_last[n0+i] !== exp_last[i]) begin
        tests_failed++;
        $display("FAIL handover[%0d]: got id=%0d expected id=%0d last=%0d", i,
                 (log_id.size() > n0 + i) ? log_id[n0+i] : -1, exp_ids[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_forced_last();
    int exp_ids[7]  = '{1, 1, 1, 1, 3, 1, 1};
    bit exp_last[7] = '{0, 0, 0, 1, 1, 0, 1};
    int n0 = log_id.size();
    push_packet(1, 6);
    push_packet(3, 1);
    run(0, 0, 80);
    for (int i = 0; i < 7; i++) begin
      tests_run++;
      if (log_id.size() <= n0 + i || log_id[n0+i] !== exp_ids[i] || log_last[n0+i] !== exp_last[i]) begin
        tests_failed++;
        $display("FAIL forced_last[%0d]: got id=%0d last=%0d expected id=%0d last=%0d", i,
                 (log_id.size() > n0 + i) ? log_id[n0+i] : -1,
                 (log_last.size() > n0 + i) ? log_last[n0+i] : 1'b0, exp_ids[i], exp_last[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int n0 = log_id.size();
    int span;
    push_packet(2, 4);
    run(1, 0, 50);
    tests_run++;
    span = (log_id.size() == n0 + 4) ? (log_cyc[n0+3] - log_cyc[n0] + 1) : -1;
    if (span != 7 || log_last[n0+3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL backpressure_span: got %0d cycles expected 7", span);
    end
  endtask

  task automatic test_foreign_ilast();
    int exp_ids[4] = '{0, 0, 0, 1};
    int n0 = log_id.size();
    push_packet(0, 3);
    push_packet(1, 1);
    run(0, 0, 50);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (log_id.size() <= n0 + i || log_id[n0+i] !== exp_ids[i]) begin
        tests_failed++;
        $display("FAIL foreign_ilast[%0d]: got id=%0d expected %0d", i,
                 (log_id.size() > n0 + i) ? log_id[n0+i] : -1, exp_ids[i]);
      end
    end
  endtask

  task automatic test_reset_midpacket();
    int n0;
    push_packet(2, 5);
    run(0, 2, 50);
    rst = 1'b1;
    drive_inputs(1'b0);
    #1;
    tests_run++;
    if ({bus.ovalid, bus.iready} !== '0) begin
      tests_failed++;
      $display("FAIL reset_abort_same_cycle: got v=%b rdy=%b expected 0", bus.ovalid, bus.iready);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_queues();
    model_reset();
    drive_inputs(1'b1);
    #1;
    tests_run++;
    if ({bus.ovalid, bus.olast, bus.iready} !== '0) begin
      tests_failed++;
      $display("FAIL reset_idle: got v=%b l=%b rdy=%b expected 0", bus.ovalid, bus.olast, bus.iready);
    end
    @(negedge clk);
    n0 = log_id.size();
    push_packet(3, 1);
    push_packet(0, 1);
    run(0, 0, 50);
    tests_run++;
    if (log_id.size() != n0 + 2 || log_id[n0] !== 0 || log_id[n0+1] !== 3) begin
      tests_failed++;
      $display("FAIL reset_ptr: got first id=%0d expected 0 then 3",
               (log_id.size() > n0) ? log_id[n0] : -1);
    end
  endtask

  task automatic test_random();
    int n0 = log_id.size();
    int total = 0;
    int len;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 20; p++) begin
        len = $urandom_range(1, 7);
        total += len;
        push_packet($urandom_range(0, NREQ - 1), len);
      end
      run(2, 0, 3000);
    end
    tests_run++;
    if (log_id.size() - n0 != total) begin
      tests_failed++;
      $display("FAIL random_beats: got %0d beats expected %0d", log_id.size() - n0, total);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_handover();
    test_forced_last();
    test_backpressure();
    test_foreign_ilast();
    test_reset_midpacket();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/adapter_arbiter.md
# adapter_arbiter

Packet-level round-robin arbiter that shares one width-adapter input port between NREQ upstream streams. Grants one requester per packet, passes that requester's beats through unchanged, and releases the grant on the last beat or when a beat limit is reached. Sits directly in front of the width adapter; its output stream drives the adapter's idata/ivalid/iready.

## Interface
- NREQ, default 4: number of requesters (≥1).
- DW, default 64: data width per requester, equal to the adapter's input width.
- MAXBEATS, default 16: maximum beats per granted packet (≥1).
- IDW, derived: max(1, $clog2(NREQ)), width of the requester index.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- idata  in  NREQ*DW  requester data, slice k = idata[k*DW +: DW].
- ivalid  in  NREQ  per-requester valid.
- ilast  in  NREQ  per-requester end-of-packet, qualified by ivalid.
- iready  out  NREQ  per-requester ready.
- odata  out  DW  data to the adapter.
- ovalid  out  1  valid to the adapter.
- olast  out  1  end of granted packet (natural or forced).
- oid  out  IDW  index of the granted requester.
- oready  in  1  ready from the adapter.

## Operation
- Two states: IDLE (no grant), BUSY (grant held by index g).
- IDLE: no data passes; ovalid=0, iready=0. If any ivalid bit is set, pick the first set bit at or after rr_ptr, scanning upward with wrap to 0; register g and move to BUSY. If none is set, stay IDLE.
- BUSY: odata = slice g; ovalid = ivalid[g]; iready[g] = oready; all other iready bits = 0; oid = g.
- olast = ivalid[g] && (ilast[g] || beat == MAXBEATS-1).
- Fire means ovalid && oready. On a fire that is not the last beat, beat increments.
- On a fire with olast=1: move to IDLE, reset beat to 0, and set rr_ptr = (g+1) mod NREQ.
- Forced olast at MAXBEATS splits the packet. The remainder is re-arbitrated as a new packet, and the requester competes at the lowest priority.
- beat counts 0..MAXBEATS-1 and never wraps.
- ilast on a requester other than g is ignored.
- Valid/ready protocol: ovalid follows ivalid[g] combinationally. Data must be held by the upstream until accepted; the block stores no data.
- A requester that deasserts ivalid mid-packet keeps the grant. Deadlock avoidance is the upstream's responsibility.

## Timing
- Reset state: IDLE, rr_ptr=0, beat=0, g=0. Outputs in reset: ovalid=0, iready=0, olast=0, oid=0.
- Reset asserted mid-packet aborts the grant in the same cycle. The partial packet is not terminated.
- Arbitration latency: 1 cycle. A request seen in IDLE at cycle t can pass its first beat at t+1.
- Throughput: one beat per cycle within a packet. There is exactly 1 bubble cycle between packets, the IDLE cycle.
- Datapath from idata/ivalid/oready to odata/ovalid/iready is combinational. Only state, g, rr_ptr and beat are registered.
- Single-beat packet (ilast on first beat): BUSY lasts 1 cycle if oready=1.
- MAXBEATS=1: every beat is olast, so each requester gets one beat per grant.
- NREQ=1: oid is tied to 0, and arbitration always selects 0.

## Structure
- Shared package adapter_pkg holds:
  - the state enum (IDLE, BUSY);
  - an IDW helper function;
  - the beat-counter width constant, $clog2(MAXBEATS) with a minimum of 1.
- One sub-module, rr_pick: combinational rotate-priority picker.
  - Inputs: NREQ-bit request vector and rr_ptr.
  - Outputs: any flag and the chosen index.
  - Reusable by other arbiters in the codebase.
- The top holds the FSM, the grant/pointer/beat registers and the output mux.

## Test plan
- After reset, all ivalid bits set with ilast=1 on every beat, oready=1: grants go 0,1,2,3,0, each one beat long, with an IDLE bubble between grants; oid matches the grant order.
- Requester 2 sends 3 beats (ilast on the third), requester 0 is pending: all 3 beats pass with oid=2, then the grant moves to 0 and rr_ptr=3.
- MAXBEATS=4, requester 1 sends 6 beats: olast is forced on beat 4. If requester 3 is waiting it is granted next; requester 1's last 2 beats follow as a new packet.
- oready toggles 1,0,1,0 during a 4-beat packet: odata and olast hold while oready=0, beat advances only on fire, and the packet completes in 7 cycles.
- rst asserted on beat 2 of a 5-beat packet: next cycle IDLE, ovalid=0, iready=0, rr_ptr=0, and requester 0 is granted first afterwards.
- ilast asserted on a non-granted requester during a grant: no effect on the grant, and beats from the granted requester continue.
